ccc_lock_reset_sequencer: RTL and testbench

CCC_LOCK_RESET_SEQUENCER -- requirements
Module: ccc_lock_reset_sequencer

---
 rtl/ccc_lock_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_ccc_lock_reset_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ccc_lock_reset_sequencer.sv
// Lock-qualified, staged reset release for fabric logic clocked by a CCC output.
// FAB_LOCK is synchronized, filtered for LOCK_FILTER_CYCLES, and then the three
// reset stages release in order, STAGE_GAP_CYCLES apart. Any loss of lock
// (or FAB_RESET) slams all stages back into reset on one edge.
module ccc_lock_reset_sequencer #(
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16
) (
  input  logic       FAB_CLK,
  input  logic       FAB_RESET,
  input  logic       FAB_LOCK,
  output logic [2:0] RST_OUT,
  output logic       READY,
  output logic [7:0] LOSS_CNT,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  rst_q, rst_d;
  logic        ready_q, ready_d;
  logic [7:0]  loss_q, loss_d;
  logic        sync1_q, sync2_q;
  logic        lock_s;

  // Saturating loss counter step: holds at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign lock_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= FAB_LOCK;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and registered outputs; reset forces everything into reset asynchronously.
  always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      rst_q   <= 3'b111;
      ready_q <= 1'b0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic; output values are computed here so they land on the same
  // edge as the state change, keeping every output a plain register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    unique case (state_q)
      IDLE: begin
        rst_d   = 3'b111;
        ready_d = 1'b0;
        cnt_d   = 16'd0;
        if (lock_s) state_d = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = RELEASE;
          cnt_d   = 16'd0;
          rst_d   = 3'b110;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          // Lock lost after release started: all stages back into reset together.
          state_d = IDLE;
          cnt_d   = 16'd0;
          rst_d   = 3'b111;
          ready_d = 1'b0;
          loss_d  = sat_inc8(loss_q);
        end else if (state_q == RELEASE) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = 16'd0;
            if (rst_q[1]) begin
              rst_d = 3'b100;
            end else begin
              rst_d   = 3'b000;
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RST_OUT  = rst_q;
  assign READY    = ready_q;
  assign LOSS_CNT = loss_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Directed bench for ccc_lock_reset_sequencer with LOCK_FILTER_CYCLES=4,
// STAGE_GAP_CYCLES=2. Edge numbering in comments: "edge 0" is the edge just
// before FAB_LOCK is raised; the lock is first captured by the synchronizer at
// edge 1, lock_s is high after edge 2, and FILTER is entered at edge 3.
module tb_ccc_lock_reset_sequencer;

  logic       FAB_CLK = 1'b0;
  logic       FAB_RESET;
  logic       FAB_LOCK;
  logic [2:0] RST_OUT;
  logic       READY;
  logic [7:0] LOSS_CNT;
  logic [1:0] STATE;

  int n_pass  = 0;
  int n_total = 0;

  ccc_lock_reset_sequencer #(
    .LOCK_FILTER_CYCLES(4),
    .STAGE_GAP_CYCLES  (2)
  ) dut (
    .FAB_CLK  (FAB_CLK),
    .FAB_RESET(FAB_RESET),
    .FAB_LOCK (FAB_LOCK),
    .RST_OUT  (RST_OUT),
    .READY    (READY),
    .LOSS_CNT (LOSS_CNT),
    .STATE    (STATE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge FAB_CLK);
      #1;
    end
  endtask

  // Full lock/release run from IDLE to RUN, then a lock drop back to IDLE.
  task automatic lock_cycle_and_drop(input string tag);
    FAB_LOCK = 1'b1;
    tick(11);
    chk({tag, "_ready"}, {7'd0, READY}, 8'd1);
    FAB_LOCK = 1'b0;
    tick(3);
  endtask

  initial begin
    FAB_RESET = 1'b0;
    FAB_LOCK  = 1'b0;
    #1 FAB_RESET = 1'b1;
    #1;
    // Reset takes effect with no clock edge yet.
    chk("por_rst_out", {5'd0, RST_OUT}, 8'h07);
    chk("por_ready",   {7'd0, READY},   8'd0);
    chk("por_loss",    LOSS_CNT,        8'd0);
    chk("por_state",   {6'd0, STATE},   8'd0);
    tick(2);
    FAB_RESET = 1'b0;
    tick(1);
    chk("idle_state", {6'd0, STATE}, 8'd0);

    // Clean lock: raised right after edge 0.
    FAB_LOCK = 1'b1;
    tick(2);                                            // edge 2
    chk("e2_state", {6'd0, STATE}, 8'd0);
    tick(1);                                            // edge 3
    chk("e3_filter", {6'd0, STATE}, 8'd1);
    tick(3);                                            // edge 6
    chk("e6_rst", {5'd0, RST_OUT}, 8'h07);
    tick(1);                                            // edge 7
    chk("e7_rst",   {5'd0, RST_OUT}, 8'h06);
    chk("e7_state", {6'd0, STATE},   8'd2);
    tick(1);                                            // edge 8
    chk("e8_rst", {5'd0, RST_OUT}, 8'h06);
    tick(1);                                            // edge 9
    chk("e9_rst", {5'd0, RST_OUT}, 8'h04);
    tick(1);                                            // edge 10
    chk("e10_ready", {7'd0, READY}, 8'd0);
    tick(1);                                            // edge 11
    chk("e11_rst",   {5'd0, RST_OUT}, 8'h00);
    chk("e11_ready", {7'd0, READY},   8'd1);
    chk("e11_state", {6'd0, STATE},   8'd3);
    chk("e11_loss",  LOSS_CNT,        8'd0);

    // Lock dropped in RUN right after edge k.
    tick(2);
    FAB_LOCK = 1'b0;
    tick(2);                                            // k+2: lock_s just fell
    chk("drop_k2_rst",   {5'd0, RST_OUT}, 8'h00);
    chk("drop_k2_ready", {7'd0, READY},   8'd1);
    tick(1);                                            // k+3
    chk("drop_k3_rst",   {5'd0, RST_OUT}, 8'h07);
    chk("drop_k3_ready", {7'd0, READY},   8'd0);
    chk("drop_k3_state", {6'd0, STATE},   8'd0);
    chk("drop_k3_loss",  LOSS_CNT,        8'd1);
    tick(2);

    // Sub-cycle glitch between edges never reaches the synchronizer.
    #2 FAB_LOCK = 1'b1;
    #3 FAB_LOCK = 1'b0;
    tick(4);
    chk("glitch_state", {6'd0, STATE},   8'd0);
    chk("glitch_rst",   {5'd0, RST_OUT}, 8'h07);

    // Lock dropped for 3 cycles during FILTER.
    FAB_LOCK = 1'b1;
    tick(3);                                            // edge 3
    chk("f_enter", {6'd0, STATE}, 8'd1);
    FAB_LOCK = 1'b0;
    tick(3);                                            // edge 6
    chk("f_exit_state", {6'd0, STATE},   8'd0);
    chk("f_exit_rst",   {5'd0, RST_OUT}, 8'h07);
    chk("f_exit_loss",  LOSS_CNT,        8'd1);

    // Restart after lock returns; reset pulsed between edges 9 and 10.
    FAB_LOCK = 1'b1;                                    // new edge 0
    tick(3);
    chk("r_e3_filter", {6'd0, STATE}, 8'd1);
    tick(4);
    chk("r_e7_rst", {5'd0, RST_OUT}, 8'h06);
    tick(2);
    chk("r_e9_rst", {5'd0, RST_OUT}, 8'h04);
    #2 FAB_RESET = 1'b1;
    #1;
    chk("ar_rst",   {5'd0, RST_OUT}, 8'h07);
    chk("ar_loss",  LOSS_CNT,        8'd0);
    chk("ar_state", {6'd0, STATE},   8'd0);
    chk("ar_ready", {7'd0, READY},   8'd0);
    FAB_RESET = 1'b0;
    tick(2);                                            // edge 11: lock_s high
    chk("ar_e11_state", {6'd0, STATE}, 8'd0);
    tick(1);                                            // edge 12: FILTER
    chk("ar_e12_filter", {6'd0, STATE}, 8'd1);
    tick(3);                                            // edge 15
    chk("ar_e15_rst", {5'd0, RST_OUT}, 8'h07);
    tick(1);                                            // edge 16
    chk("ar_e16_rst", {5'd0, RST_OUT}, 8'h06);
    tick(4);                                            // edge 20
    chk("ar_e20_rst",   {5'd0, RST_OUT}, 8'h00);
    chk("ar_e20_ready", {7'd0, READY},   8'd1);

    // Back to IDLE via a lock loss in RUN.
    FAB_LOCK = 1'b0;
    tick(3);
    chk("l1_loss", LOSS_CNT, 8'd1);
    tick(2);

    // One-cycle lock pulse in IDLE.
    FAB_LOCK = 1'b1;
    tick(1);
    FAB_LOCK = 1'b0;
    tick(2);
    chk("pulse_filter", {6'd0, STATE},   8'd1);
    chk("pulse_rst1",   {5'd0, RST_OUT}, 8'h07);
    tick(1);
    chk("pulse_idle",   {6'd0, STATE},   8'd0);
    chk("pulse_rst2",   {5'd0, RST_OUT}, 8'h07);
    tick(2);
    chk("pulse_loss",   LOSS_CNT,        8'd1);

    // Saturation: 254 more losses in RUN reach 255, 5 more must hold it.
    for (int i = 0; i < 254; i++) lock_cycle_and_drop("sat_a");
    chk("sat_255", LOSS_CNT, 8'd255);
    for (int i = 0; i < 5; i++) lock_cycle_and_drop("sat_b");
    chk("sat_hold",  LOSS_CNT,        8'd255);
    chk("sat_rst",   {5'd0, RST_OUT}, 8'h07);
    chk("sat_state", {6'd0, STATE},   8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
